rbs4_pipe: RTL and testbench
============================

Name: rbs4_pipe

Overview:
- Pipelined ripple-borrow subtractor; computes D = X − Y − Bi. It is the inverse operation of the team's registered-carry ripple adder.
- One bit-slice per pipeline stage, with borrow registered between slices. This mirrors the adder's registered-carry structure in the subtract direction.
- Sits behind the same operand source as the adder. Uses a valid/ready handshake so it can be stalled by a downstream consumer.

Parameters:
- WIDTH, 4: operand width in bits; equals pipeline depth and latency.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block accepts beat this cycle
- X  in  WIDTH  minuend, unsigned
- Y  in  WIDTH  subtrahend, unsigned
- Bi  in  1  borrow-in
- out_valid  out  1  result beat valid
- out_ready  in  1  consumer accepts result
- D  out  WIDTH  difference, modulo 2^WIDTH
- Bo  out  1  borrow-out (1 when X < Y + Bi)
- Ov  out  1  signed overflow (two's-complement interpretation)

Behaviour:
- Single clock clk; rst is synchronous and active-high. All state is cleared on a clk edge with rst=1.
- Reset values: every stage valid bit = 0, out_valid = 0, D = 0, Bo = 0, Ov = 0. in_ready = 1 in the first cycle after reset.
- Stage k (0..WIDTH-1) computes bit k of the difference:
  - d_k = X_k ^ Y_k ^ b_k
  - b_{k+1} = (~X_k & Y_k) | (~(X_k ^ Y_k) & b_k)
  - b_0 = Bi
- Stage k registers the following:
  - d_k and b_{k+1}.
  - Upper operand bits X/Y[WIDTH-1:k+1] (skew-in).
  - Already computed d[k-1:0] (deskew).
  - Sign bits X/Y[WIDTH-1], carried through for Ov.
  - Its own valid bit v_k.
- Final stage drives:
  - D = {d_{W-1}..d_0}
  - Bo = b_W
  - Ov = (X_msb ^ Y_msb) & (X_msb ^ d_{W-1})
  - out_valid = v_{W-1}
- Advance: adv = out_ready | ~out_valid. The whole pipeline shifts one stage when adv = 1 and holds all registers when adv = 0.
- in_ready = adv, a combinational function of out_ready and out_valid only. in_ready must not depend on in_valid.
- Accept: a beat enters stage 0 when in_valid & in_ready. If in_valid = 0 while adv = 1, v_0 <= 0 and a bubble enters.
- Latency: a beat accepted at edge n appears with out_valid = 1 after edge n+WIDTH−1, assuming no stalls. Sustained throughput is 1 beat/clk with out_ready held high.
- Stall: D/Bo/Ov must hold stable while out_valid = 1 & out_ready = 0. Internal bubbles are not squeezed during a stall.
- Wrap-around: D is modulo 2^WIDTH. Example for WIDTH=4: 0 − 1 gives D = 15, Bo = 1.
- Bi = 1 with X = Y gives D = all ones, Bo = 1.
- Simultaneous output-accept and input-accept in the same cycle is legal, with no beat lost or duplicated.
- rst asserted mid-operation: all in-flight beats are discarded. No out_valid is asserted in the cycle after reset.

Decomposition:
- Shared package rbs_pkg holds:
  - RBS_WIDTH default constant (4).
  - Typedef of the operand word.
  - Typedef of the per-stage payload struct: x/y skew bits, d deskew bits, borrow, sign bits, valid.
- One sub-module, rbs_stage: a single bit-slice full subtractor plus its payload register with enable.
- rbs4_pipe generates WIDTH instances of rbs_stage and the adv/in_ready logic.

Test Plan:
- Directed subtractions at WIDTH=4:
  - X=5, Y=3, Bi=0 -> D=2, Bo=0, Ov=0, out_valid 4 cycles after accept.
  - X=3, Y=5, Bi=0 -> D=14, Bo=1, Ov=0.
  - X=0, Y=0, Bi=1 -> D=15, Bo=1.
  - X=8 (−8), Y=1, Bi=0 -> D=7, Bo=0, Ov=1.
- Back-to-back: 16 consecutive beats with out_ready=1 -> 16 results on consecutive cycles, in order. Each result is checked against a (X−Y−Bi) mod 16 reference model.
- Backpressure: hold out_ready=0 for 5 cycles with the pipeline full -> in_ready=0 and D/Bo stable throughout. On release, all results drain in order with none lost or duplicated.
- Reset mid-flight: accept 3 beats, assert rst for 1 cycle -> out_valid stays 0 and D=0, Bo=0. The next accepted beat (X=9, Y=4) yields D=5 after 4 cycles.
- Exhaustive sweep: all 512 combinations of X, Y, Bi with randomized in_valid/out_ready toggling -> every result matches the model, and output order equals input order.

Source files
------------

// File: rtl/rbs_pkg.sv
// rbs_pkg: shared types and helpers for the pipelined ripple-borrow subtractor.
//
// Contents:
//   RBS_WIDTH     - default operand width, which is also the pipeline depth
//   rbs_word_t    - one operand or result word
//   rbs_payload_t - the record carried from one bit-slice stage to the next
//   rbs_sub_bit   - one-bit full subtractor, returns {borrow_out, diff}

package rbs_pkg;

  localparam int RBS_WIDTH = 4;

  typedef logic [RBS_WIDTH-1:0] rbs_word_t;

  // Operand words travel down the pipe whole. Each stage only reads its own
  // bit of x/y and only writes its own bit of d. The stale low operand bits
  // and the not-yet-computed high difference bits have no loads, so they
  // fall away after synthesis. What remains is the skew/deskew triangle.
  typedef struct packed {
    rbs_word_t x;
    rbs_word_t y;
    rbs_word_t d;
    logic      borrow;
    logic      x_msb;
    logic      y_msb;
    logic      valid;
  } rbs_payload_t;

  function automatic logic [1:0] rbs_sub_bit(input logic x, input logic y, input logic b);
    return {(~x & y) | (~(x ^ y) & b), x ^ y ^ b};
  endfunction

endpackage

// File: rtl/rbs_stage.sv
// rbs_stage: one bit-slice of the ripple-borrow subtractor plus its payload
// register.
//
// Parameters:
//   K      - bit position this slice computes
// Ports:
//   clk    - rising-edge clock
//   rst    - synchronous active-high reset, clears the whole payload
//   en     - pipeline advance; the register holds when low
//   pay_i  - payload from the previous stage (or the operand source)
//   pay_o  - registered payload with d[K] and the outgoing borrow filled in

module rbs_stage
  import rbs_pkg::*;
#(
  parameter int K = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  rbs_payload_t pay_i,
  output rbs_payload_t pay_o
);

  logic [1:0]   sub_bits;
  rbs_payload_t pay_d;
  rbs_payload_t pay_q;

  // Subtract bit K using the borrow registered by the previous slice.
  // Everything else passes through unchanged. d[K] arrives as zero from
  // upstream, so OR-ing the new bit in is enough to place it.
  always_comb begin
    sub_bits     = rbs_sub_bit(pay_i.x[K], pay_i.y[K], pay_i.borrow);
    pay_d        = pay_i;
    pay_d.d      = pay_i.d | (rbs_word_t'(sub_bits[0]) << K);
    pay_d.borrow = sub_bits[1];
  end

  // Payload register. Reset clears valid together with the data, so any
  // beat in flight is discarded. When en is low, the register keeps its
  // contents and passes nothing down the pipe.
  always_ff @(posedge clk) begin
    if (rst) begin
      pay_q <= '0;
    end else if (en) begin
      pay_q <= pay_d;
    end
  end

  assign pay_o = pay_q;

endmodule

// File: rtl/rbs4_pipe.sv
// rbs4_pipe: pipelined ripple-borrow subtractor, D = X - Y - Bi.
// It has one bit-slice per stage, with the borrow registered between
// slices. Latency and depth both equal WIDTH. A valid/ready handshake on
// both sides lets a downstream consumer stall the pipe.
//
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   in_valid / in_ready  - operand beat handshake
//   X, Y, Bi             - minuend, subtrahend, borrow-in
//   out_valid / out_ready- result beat handshake
//   D, Bo, Ov            - difference mod 2^WIDTH, borrow-out, signed overflow

module rbs4_pipe
  import rbs_pkg::*;
#(
  parameter int WIDTH = RBS_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             Bi,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             Bo,
  output logic             Ov
);

  logic         adv;
  logic         unused_skew;
  rbs_payload_t stage_in;
  rbs_payload_t pay [WIDTH];

  // The whole pipe moves in lockstep. It shifts whenever the output slot
  // is empty or is being drained. Bubbles inside the pipe are not squeezed
  // out during a stall. in_ready therefore depends only on the output side.
  always_comb begin
    adv      = out_ready | ~out_valid;
    in_ready = adv;
  end

  // Build the payload for stage 0. When no beat is offered, an all-zero
  // bubble enters instead. A bubble's D/Bo/Ov read as zero when it reaches
  // the output.
  always_comb begin
    stage_in = '0;
    if (in_valid) begin
      stage_in.x      = X;
      stage_in.y      = Y;
      stage_in.borrow = Bi;
      stage_in.x_msb  = X[WIDTH-1];
      stage_in.y_msb  = Y[WIDTH-1];
      stage_in.valid  = 1'b1;
    end
  end

  for (genvar k = 0; k < WIDTH; k++) begin : g_stage
    if (k == 0) begin : g_first
      rbs_stage #(.K(k)) u_stage (
        .clk   (clk),
        .rst   (rst),
        .en    (adv),
        .pay_i (stage_in),
        .pay_o (pay[k])
      );
    end else begin : g_rest
      rbs_stage #(.K(k)) u_stage (
        .clk   (clk),
        .rst   (rst),
        .en    (adv),
        .pay_i (pay[k-1]),
        .pay_o (pay[k])
      );
    end
  end

  // Drive the outputs from the last stage. Overflow happens when the
  // operand signs differ and the result sign differs from the minuend sign.
  always_comb begin
    out_valid = pay[WIDTH-1].valid;
    D         = pay[WIDTH-1].d;
    Bo        = pay[WIDTH-1].borrow;
    Ov        = (pay[WIDTH-1].x_msb ^ pay[WIDTH-1].y_msb)
              & (pay[WIDTH-1].x_msb ^ pay[WIDTH-1].d[WIDTH-1]);
  end

  assign unused_skew = ^{pay[WIDTH-1].x, pay[WIDTH-1].y};

endmodule

// File: tb/tb_rbs4_pipe.sv
// tb_rbs4_pipe: self-checking bench for rbs4_pipe at WIDTH=4.
// It covers directed vectors, back-to-back streaming, backpressure, reset
// in mid-flight, and a full X/Y/Bi sweep with random handshake toggling.

module tb_rbs4_pipe;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] X;
  logic [W-1:0] Y;
  logic         Bi;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] D;
  logic         Bo;
  logic         Ov;

  int numVectors     = 0;
  int numMiscompares = 0;

  logic [5:0] expQ [$];
  logic [5:0] expVal;
  int         pushCount = 0;
  int         popCount  = 0;
  int         cycleCnt  = 0;
  int         lastPop   = 0;
  logic       scoreOn   = 1'b0;
  logic       gapOn     = 1'b0;
  logic       havePrev  = 1'b0;

  typedef struct {
    logic [3:0] x;
    logic [3:0] y;
    logic       bi;
    logic [3:0] d;
    logic       bo;
    logic       ov;
  } vec_t;

  vec_t vecs [9];

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  rbs4_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .X         (X),
    .Y         (Y),
    .Bi        (Bi),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .D         (D),
    .Bo        (Bo),
    .Ov        (Ov)
  );

  // Reference model written in plain integer arithmetic. It returns
  // {D, Bo, Ov}, with overflow taken from the true signed result.
  function automatic logic [5:0] refModel(input logic [3:0] x, input logic [3:0] y, input logic bi);
    int         diff;
    int         sd;
    logic [3:0] d;
    logic       bo;
    logic       ov;
    diff = int'(x) - int'(y) - int'(bi);
    d    = diff[3:0];
    bo   = (diff < 0);
    sd   = int'($signed(x)) - int'($signed(y)) - int'(bi);
    ov   = (sd < -8) || (sd > 7);
    return {d, bo, ov};
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    numVectors++;
    if (actual != expected) begin
      numMiscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Present one beat, then count edges from acceptance until out_valid
  // rises. The wait is bounded; lat comes back as 20 on timeout.
  task automatic applyStimulus(input logic [3:0] x, input logic [3:0] y, input logic bi,
                               output int lat);
    @(negedge clk);
    X         = x;
    Y         = y;
    Bi        = bi;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat      = 0;
    #1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      #1;
      lat++;
    end
  endtask

  // Wait, with a bound, until every scoreboarded beat has come out.
  task automatic waitDrain(input string name);
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 60) begin
      @(negedge clk);
      #2;
      n++;
    end
    checkOutput(name, expQ.size(), 0);
  endtask

  // Scoreboard monitor. It samples just after each falling edge, when both
  // handshakes are stable. Accepted inputs are pushed through the reference
  // model. Accepted outputs are popped in order. In back-to-back mode it
  // also checks that results arrive on consecutive cycles.
  always begin
    @(negedge clk);
    #1;
    cycleCnt++;
    if (!gapOn) havePrev = 1'b0;
    if (scoreOn) begin
      if (in_valid && in_ready) begin
        expQ.push_back(refModel(X, Y, Bi));
        pushCount++;
      end
      if (out_valid && out_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_result", 1, 0);
        end else begin
          expVal = expQ.pop_front();
          checkOutput("result_D_Bo_Ov", int'({D, Bo, Ov}), int'(expVal));
          popCount++;
          if (gapOn && havePrev) checkOutput("b2b_gap", cycleCnt - lastPop, 1);
          havePrev = gapOn;
          lastPop  = cycleCnt;
        end
      end
    end
  end

  // Watchdog so that the run always ends, even if the DUT wedges.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence.
  initial begin
    int         lat;
    int         p0;
    int         idx;
    int         guard;
    logic [5:0] expBp0;

    rst       = 1'b1;
    in_valid  = 1'b0;
    X         = '0;
    Y         = '0;
    Bi        = 1'b0;
    out_ready = 1'b1;

    vecs[0] = '{4'd5,  4'd3,  1'b0, 4'd2,  1'b0, 1'b0};
    vecs[1] = '{4'd3,  4'd5,  1'b0, 4'd14, 1'b1, 1'b0};
    vecs[2] = '{4'd0,  4'd0,  1'b1, 4'd15, 1'b1, 1'b0};
    vecs[3] = '{4'd8,  4'd1,  1'b0, 4'd7,  1'b0, 1'b1};
    vecs[4] = '{4'd0,  4'd1,  1'b0, 4'd15, 1'b1, 1'b0};
    vecs[5] = '{4'd7,  4'd7,  1'b1, 4'd15, 1'b1, 1'b0};
    vecs[6] = '{4'd7,  4'd15, 1'b0, 4'd8,  1'b1, 1'b1};
    vecs[7] = '{4'd15, 4'd15, 1'b0, 4'd0,  1'b0, 1'b0};
    vecs[8] = '{4'd9,  4'd4,  1'b0, 4'd5,  1'b0, 1'b1};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_D", D, 0);
    checkOutput("reset_Bo", Bo, 0);
    checkOutput("reset_Ov", Ov, 0);
    checkOutput("reset_in_ready", in_ready, 1);

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].x, vecs[i].y, vecs[i].bi, lat);
      checkOutput($sformatf("vec%0d_latency", i), lat, W - 1);
      checkOutput($sformatf("vec%0d_D", i), D, vecs[i].d);
      checkOutput($sformatf("vec%0d_Bo", i), Bo, vecs[i].bo);
      checkOutput($sformatf("vec%0d_Ov", i), Ov, vecs[i].ov);
    end
    repeat (2) @(negedge clk);

    scoreOn = 1'b1;
    gapOn   = 1'b1;
    p0      = popCount;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      X        = 4'(i);
      Y        = 4'((i * 7 + 3) % 16);
      Bi       = i[0];
      in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    waitDrain("b2b_drain");
    checkOutput("b2b_count", popCount - p0, 16);
    gapOn = 1'b0;

    @(negedge clk);
    out_ready = 1'b0;
    p0        = popCount;
    expBp0    = refModel(4'd12, 4'd5, 1'b0);
    for (int i = 0; i < 4; i++) begin
      case (i)
        0:       begin X = 4'd12; Y = 4'd5;  Bi = 1'b0; end
        1:       begin X = 4'd2;  Y = 4'd9;  Bi = 1'b1; end
        2:       begin X = 4'd6;  Y = 4'd6;  Bi = 1'b0; end
        default: begin X = 4'd15; Y = 4'd0;  Bi = 1'b1; end
      endcase
      in_valid = 1'b1;
      @(negedge clk);
    end
    X        = 4'd1;
    Y        = 4'd14;
    Bi       = 1'b0;
    in_valid = 1'b1;
    #1;
    checkOutput("bp_full_valid", out_valid, 1);
    checkOutput("bp_first_result", int'({D, Bo, Ov}), int'(expBp0));
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      checkOutput("bp_in_ready", in_ready, 0);
      checkOutput("bp_out_valid", out_valid, 1);
      checkOutput("bp_hold", int'({D, Bo, Ov}), int'(expBp0));
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    waitDrain("bp_drain");
    checkOutput("bp_count", popCount - p0, 5);
    repeat (2) @(negedge clk);

    scoreOn = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      X        = 4'(i + 10);
      Y        = 4'(i);
      Bi       = 1'b1;
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_D", D, 0);
      checkOutput("rst_Bo", Bo, 0);
      @(negedge clk);
    end
    applyStimulus(4'd9, 4'd4, 1'b0, lat);
    checkOutput("post_rst_latency", lat, W - 1);
    checkOutput("post_rst_D", D, 5);
    checkOutput("post_rst_Bo", Bo, 0);
    repeat (2) @(negedge clk);

    scoreOn = 1'b1;
    p0      = popCount;
    idx     = 0;
    guard   = 0;
    while (idx < 512 && guard < 6000) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      X         = idx[3:0];
      Y         = idx[7:4];
      Bi        = idx[8];
      #1;
      if (in_valid && in_ready) idx++;
      guard++;
    end
    checkOutput("sweep_accepted", idx, 512);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    waitDrain("sweep_drain");
    checkOutput("sweep_count", popCount - p0, 512);

    $display("== %0d vectors applied, %0d miscompares ==", numVectors, numMiscompares);
    $finish;
  end

endmodule
